// File: rtl/pzcorebus_memory_responder.sv
// Corebus target endpoint backed by a resettable register-array memory.
// Optional per-byte write enables: PZCOREBUS_MEMORY_RESPONDER_BYTE_ENABLE_EN.
module pzcorebus_memory_responder #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = 8,
    parameter int LENGTH_WIDTH  = 4,
    parameter int MEMORY_DEPTH  = 256
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_mcmd_valid,
    output logic                      o_scmd_accept,
    input  logic [1:0]                i_mcmd,
    input  logic [ID_WIDTH-1:0]       i_mid,
    input  logic [ADDRESS_WIDTH-1:0]  i_maddr,
    input  logic [LENGTH_WIDTH-1:0]   i_mlength,
    input  logic                      i_mdata_valid,
    output logic                      o_sdata_accept,
    input  logic [DATA_WIDTH-1:0]     i_mdata,
`ifdef PZCOREBUS_MEMORY_RESPONDER_BYTE_ENABLE_EN
    input  logic [DATA_WIDTH/8-1:0]   i_mdata_byteen,
`endif
    input  logic                      i_mdata_last,
    output logic                      o_sresp_valid,
    input  logic                      i_mresp_accept,
    output logic                      o_sresp,
    output logic [ID_WIDTH-1:0]       o_sid,
    output logic                      o_serror,
    output logic [DATA_WIDTH-1:0]     o_sdata,
    output logic                      o_sresp_last
);
    // state      | meaning
    // IDLE       | waiting for a command
    // WRITE      | consuming write beats
    // WRITE_RESP | single ack for a non-posted write
    // READ       | streaming read beats
    // ERR_RESP   | single error ack for a reserved command
    typedef enum logic [2:0] {IDLE, WRITE, WRITE_RESP, READ, ERR_RESP} state_t;

    localparam int IDX_W = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;

    state_t                    state;
    logic [DATA_WIDTH-1:0]     mem [MEMORY_DEPTH];
    logic [ADDRESS_WIDTH-1:0]  addr;
    logic [ADDRESS_WIDTH-1:0]  addr_next;
    logic [LENGTH_WIDTH-1:0]   remaining;
    logic [ID_WIDTH-1:0]       id;
    logic                      err;
    logic                      nonposted;
    logic                      wr_err;
    logic                      mem_we;
    logic [IDX_W-1:0]          idx;
    logic [DATA_WIDTH-1:0]     wr_word;

    function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
        return {1'b0, a} < (ADDRESS_WIDTH+1)'(MEMORY_DEPTH);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] read_word(input logic [ADDRESS_WIDTH-1:0] a);
        if (in_range(a)) return mem[a[IDX_W-1:0]];
        return '0;
    endfunction

    assign addr_next = addr + 1'b1;
    assign idx       = addr[IDX_W-1:0];
    assign mem_we    = (state == WRITE) && i_mdata_valid && o_sdata_accept && in_range(addr);

    // A misplaced or missing last marker flags the burst but never shortens it.
    always_comb begin
        wr_err = err | ~in_range(addr) | ((remaining == '0) ? ~i_mdata_last : i_mdata_last);
    end

    always_comb begin
        wr_word = i_mdata;
`ifdef PZCOREBUS_MEMORY_RESPONDER_BYTE_ENABLE_EN
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            wr_word[8*b +: 8] = i_mdata_byteen[b] ? i_mdata[8*b +: 8] : mem[idx][8*b +: 8];
        end
`endif
    end

    for (genvar w = 0; w < MEMORY_DEPTH; w++) begin : g_word
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)                           mem[w] <= '0;
            else if (mem_we && idx == IDX_W'(w))    mem[w] <= wr_word;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            addr           <= '0;
            remaining      <= '0;
            id             <= '0;
            err            <= 1'b0;
            nonposted      <= 1'b0;
            o_scmd_accept  <= 1'b0;
            o_sdata_accept <= 1'b0;
            o_sresp_valid  <= 1'b0;
            o_sresp        <= 1'b0;
            o_sid          <= '0;
            o_serror       <= 1'b0;
            o_sdata        <= '0;
            o_sresp_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_mcmd_valid && o_scmd_accept) begin
                        o_scmd_accept <= 1'b0;
                        addr          <= i_maddr;
                        remaining     <= i_mlength;
                        id            <= i_mid;
                        err           <= 1'b0;
                        nonposted     <= (i_mcmd == 2'd2);
                        case (i_mcmd)
                            2'd0: begin
                                state         <= READ;
                                o_sresp_valid <= 1'b1;
                                o_sresp       <= 1'b1;
                                o_sid         <= i_mid;
                                o_sdata       <= read_word(i_maddr);
                                o_serror      <= ~in_range(i_maddr);
                                o_sresp_last  <= (i_mlength == '0);
                            end
                            2'd1, 2'd2: begin
                                state          <= WRITE;
                                o_sdata_accept <= 1'b1;
                            end
                            default: begin
                                state         <= ERR_RESP;
                                o_sresp_valid <= 1'b1;
                                o_sresp       <= 1'b0;
                                o_sid         <= i_mid;
                                o_sdata       <= '0;
                                o_serror      <= 1'b1;
                                o_sresp_last  <= 1'b1;
                            end
                        endcase
                    end else begin
                        o_scmd_accept <= 1'b1;
                    end
                end
                WRITE: begin
                    if (i_mdata_valid && o_sdata_accept) begin
                        addr      <= addr_next;
                        remaining <= remaining - 1'b1;
                        err       <= wr_err;
                        if (remaining == '0) begin
                            o_sdata_accept <= 1'b0;
                            if (nonposted) begin
                                state         <= WRITE_RESP;
                                o_sresp_valid <= 1'b1;
                                o_sresp       <= 1'b0;
                                o_sid         <= id;
                                o_sdata       <= '0;
                                o_serror      <= wr_err;
                                o_sresp_last  <= 1'b1;
                            end else begin
                                state         <= IDLE;
                                o_scmd_accept <= 1'b1;
                            end
                        end
                    end
                end
                READ: begin
                    if (i_mresp_accept) begin
                        if (remaining == '0) begin
                            state         <= IDLE;
                            o_scmd_accept <= 1'b1;
                            o_sresp_valid <= 1'b0;
                            o_sresp       <= 1'b0;
                            o_sid         <= '0;
                            o_serror      <= 1'b0;
                            o_sdata       <= '0;
                            o_sresp_last  <= 1'b0;
                        end else begin
                            addr         <= addr_next;
                            remaining    <= remaining - 1'b1;
                            o_sdata      <= read_word(addr_next);
                            o_serror     <= ~in_range(addr_next);
                            o_sresp_last <= (remaining == LENGTH_WIDTH'(1));
                        end
                    end
                end
                WRITE_RESP, ERR_RESP: begin
                    if (i_mresp_accept) begin
                        state         <= IDLE;
                        o_scmd_accept <= 1'b1;
                        o_sresp_valid <= 1'b0;
                        o_sresp       <= 1'b0;
                        o_sid         <= '0;
                        o_serror      <= 1'b0;
                        o_sdata       <= '0;
                        o_sresp_last  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pzcorebus_memory_responder.sv
// Directed self-checking bench for pzcorebus_memory_responder.
module tb_pzcorebus_memory_responder;
    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_mcmd_valid;
    logic        o_scmd_accept;
    logic [1:0]  i_mcmd;
    logic [7:0]  i_mid;
    logic [15:0] i_maddr;
    logic [3:0]  i_mlength;
    logic        i_mdata_valid;
    logic        o_sdata_accept;
    logic [31:0] i_mdata;
    logic [3:0]  i_mdata_byteen;
    logic        i_mdata_last;
    logic        o_sresp_valid;
    logic        i_mresp_accept;
    logic        o_sresp;
    logic [7:0]  o_sid;
    logic        o_serror;
    logic [31:0] o_sdata;
    logic        o_sresp_last;

    int errors = 0;
    int checks = 0;

    pzcorebus_memory_responder dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_mcmd_valid   (i_mcmd_valid),
        .o_scmd_accept  (o_scmd_accept),
        .i_mcmd         (i_mcmd),
        .i_mid          (i_mid),
        .i_maddr        (i_maddr),
        .i_mlength      (i_mlength),
        .i_mdata_valid  (i_mdata_valid),
        .o_sdata_accept (o_sdata_accept),
        .i_mdata        (i_mdata),
`ifdef PZCOREBUS_MEMORY_RESPONDER_BYTE_ENABLE_EN
        .i_mdata_byteen (i_mdata_byteen),
`endif
        .i_mdata_last   (i_mdata_last),
        .o_sresp_valid  (o_sresp_valid),
        .i_mresp_accept (i_mresp_accept),
        .o_sresp        (o_sresp),
        .o_sid          (o_sid),
        .o_serror       (o_serror),
        .o_sdata        (o_sdata),
        .o_sresp_last   (o_sresp_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic send_cmd(input logic [1:0] cmd, input logic [7:0] id,
                            input logic [15:0] addr, input logic [3:0] len);
        logic acc;
        bit   done = 0;
        i_mcmd_valid = 1'b1; i_mcmd = cmd; i_mid = id; i_maddr = addr; i_mlength = len;
        for (int n = 0; n < 20 && !done; n++) begin
            acc = o_scmd_accept;
            @(posedge i_clk); #1;
            if (acc) done = 1;
        end
        i_mcmd_valid = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL cmd_accept_timeout: no accept seen, required accept within 20 cycles"); end
    endtask

    task automatic send_data(input logic [31:0] data, input logic last, input logic [3:0] be);
        logic acc;
        bit   done = 0;
        i_mdata_valid = 1'b1; i_mdata = data; i_mdata_last = last; i_mdata_byteen = be;
        for (int n = 0; n < 20 && !done; n++) begin
            acc = o_sdata_accept;
            @(posedge i_clk); #1;
            if (acc) done = 1;
        end
        i_mdata_valid = 1'b0; i_mdata_last = 1'b0;
        checks++;
        if (!done) begin errors++; $display("FAIL data_accept_timeout: no accept seen, required accept within 20 cycles"); end
    endtask

    // Waits for a beat, optionally stalls it for hold cycles, then accepts it.
    task automatic get_beat(input int hold, output logic resp, output logic [7:0] id,
                            output logic err, output logic [31:0] data, output logic last,
                            output logic stable);
        int n = 0;
        i_mresp_accept = 1'b0;
        while (!o_sresp_valid && n < 20) begin @(posedge i_clk); #1; n++; end
        checks++;
        if (!o_sresp_valid) begin errors++; $display("FAIL resp_timeout: valid=0, required valid=1 within 20 cycles"); end
        resp = o_sresp; id = o_sid; err = o_serror; data = o_sdata; last = o_sresp_last;
        stable = 1'b1;
        repeat (hold) begin
            @(posedge i_clk); #1;
            if (!o_sresp_valid || o_sresp !== resp || o_sid !== id || o_serror !== err ||
                o_sdata !== data || o_sresp_last !== last) stable = 1'b0;
        end
        i_mresp_accept = 1'b1;
        @(posedge i_clk); #1;
        i_mresp_accept = 1'b0;
    endtask

    task automatic test_reset();
        logic r, e, l, s; logic [7:0] id; logic [31:0] d;
        i_rst_n = 1'b0; i_mcmd_valid = 0; i_mcmd = 0; i_mid = 0; i_maddr = 0; i_mlength = 0;
        i_mdata_valid = 0; i_mdata = 0; i_mdata_last = 0; i_mdata_byteen = 4'hF; i_mresp_accept = 0;
        repeat (3) @(posedge i_clk); #1;
        checks++;
        if ({o_scmd_accept, o_sdata_accept, o_sresp_valid, o_sresp, o_serror, o_sresp_last, o_sid, o_sdata} !== '0) begin
            errors++; $display("FAIL reset_outputs: got acc=%b dacc=%b v=%b sid=%h sdata=%h, required all 0",
                               o_scmd_accept, o_sdata_accept, o_sresp_valid, o_sid, o_sdata);
        end
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_scmd_accept !== 1'b1) begin errors++; $display("FAIL reset_release_accept: got %b required 1", o_scmd_accept); end
        send_cmd(2'd0, 8'h01, 16'h0005, 4'd0);
        checks++;
        if (o_sresp_valid !== 1'b1) begin errors++; $display("FAIL read_first_latency: valid got %b required 1", o_sresp_valid); end
        get_beat(0, r, id, e, d, l, s);
        checks++;
        if ({r, id, e, d, l} !== {1'b1, 8'h01, 1'b0, 32'h0, 1'b1}) begin
            errors++; $display("FAIL reset_read: got resp=%b id=%h err=%b data=%h last=%b required 1 01 0 0 1", r, id, e, d, l);
        end
        checks++;
        if (o_sresp_valid !== 1'b0) begin errors++; $display("FAIL read_done_valid: got %b required 0", o_sresp_valid); end
    endtask

    task automatic test_write_read();
        logic r, e, l, s; logic [7:0] id; logic [31:0] d;
        logic [31:0] wdata [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        send_cmd(2'd2, 8'h3C, 16'h0010, 4'd3);
        for (int i = 0; i < 4; i++) send_data(wdata[i], i == 3, 4'hF);
        get_beat(0, r, id, e, d, l, s);
        checks++;
        if ({r, id, e, l} !== {1'b0, 8'h3C, 1'b0, 1'b1}) begin
            errors++; $display("FAIL np_write_ack: got resp=%b id=%h err=%b last=%b required 0 3c 0 1", r, id, e, l);
        end
        send_cmd(2'd0, 8'h3D, 16'h0010, 4'd3);
        for (int i = 0; i < 4; i++) begin
            get_beat(0, r, id, e, d, l, s);
            checks++;
            if ({r, id, e, d, l} !== {1'b1, 8'h3D, 1'b0, wdata[i], i == 3}) begin
                errors++; $display("FAIL read_back beat %0d: got resp=%b id=%h err=%b data=%h last=%b required data=%h last=%b",
                                   i, r, id, e, d, l, wdata[i], i == 3);
            end
        end
    endtask

    task automatic test_back_pressure();
        logic r, e, l, s; logic [7:0] id; logic [31:0] d;
        logic [31:0] exp [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
        send_cmd(2'd0, 8'h55, 16'h0010, 4'd3);
        for (int i = 0; i < 4; i++) begin
            get_beat((i == 1) ? 5 : 0, r, id, e, d, l, s);
            checks++;
            if ({id, d, l, s} !== {8'h55, exp[i], i == 3, 1'b1}) begin
                errors++; $display("FAIL stall_beat %0d: got id=%h data=%h last=%b stable=%b required 55 %h %b 1",
                                   i, id, d, l, s, exp[i], i == 3);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic r, e, l, s; logic [7:0] id; logic [31:0] d;
        logic        seen = 1'b0;
        logic [31:0] expd [4] = '{32'hB1, 32'hB2, 32'h0, 32'h0};
        logic        expe [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        send_cmd(2'd1, 8'h21, 16'h00FE, 4'd3);
        for (int i = 0; i < 4; i++) send_data(32'hA1 + i, i == 3, 4'hF);
        repeat (3) begin @(posedge i_clk); #1; if (o_sresp_valid) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL posted_no_resp: response seen=%b required 0", seen); end
        send_cmd(2'd0, 8'h23, 16'h00FE, 4'd1);
        for (int i = 0; i < 2; i++) begin
            get_beat(0, r, id, e, d, l, s);
            checks++;
            if ({d, e} !== {32'hA1 + i, 1'b0}) begin
                errors++; $display("FAIL posted_data beat %0d: got data=%h err=%b required %h 0", i, d, e, 32'hA1 + i);
            end
        end
        send_cmd(2'd2, 8'h22, 16'h00FE, 4'd3);
        for (int i = 0; i < 4; i++) send_data(32'hB1 + i, i == 3, 4'hF);
        get_beat(0, r, id, e, d, l, s);
        checks++;
        if ({r, id, e, l} !== {1'b0, 8'h22, 1'b1, 1'b1}) begin
            errors++; $display("FAIL oor_write_ack: got resp=%b id=%h err=%b last=%b required 0 22 1 1", r, id, e, l);
        end
        send_cmd(2'd0, 8'h24, 16'h00FE, 4'd3);
        for (int i = 0; i < 4; i++) begin
            get_beat(0, r, id, e, d, l, s);
            checks++;
            if ({d, e, l} !== {expd[i], expe[i], i == 3}) begin
                errors++; $display("FAIL oor_read beat %0d: got data=%h err=%b last=%b required %h %b %b",
                                   i, d, e, l, expd[i], expe[i], i == 3);
            end
        end
    endtask

    task automatic test_last_marker_and_reserved();
        logic r, e, l, s; logic [7:0] id; logic [31:0] d;
        send_cmd(2'd2, 8'h40, 16'h0020, 4'd1);
        send_data(32'h5A, 1'b1, 4'hF);
        checks++;
        if (o_sdata_accept !== 1'b1) begin errors++; $display("FAIL early_last_continues: dacc got %b required 1", o_sdata_accept); end
        send_data(32'h5B, 1'b0, 4'hF);
        get_beat(0, r, id, e, d, l, s);
        checks++;
        if ({r, id, e, l} !== {1'b0, 8'h40, 1'b1, 1'b1}) begin
            errors++; $display("FAIL early_last_ack: got resp=%b id=%h err=%b last=%b required 0 40 1 1", r, id, e, l);
        end
        send_cmd(2'd0, 8'h41, 16'h0020, 4'd1);
        for (int i = 0; i < 2; i++) begin
            get_beat(0, r, id, e, d, l, s);
            checks++;
            if (d !== 32'h5A + i) begin errors++; $display("FAIL early_last_data beat %0d: got %h required %h", i, d, 32'h5A + i); end
        end
        send_cmd(2'd2, 8'h42, 16'h0022, 4'd0);
        send_data(32'h5C, 1'b0, 4'hF);
        get_beat(0, r, id, e, d, l, s);
        checks++;
        if ({id, e} !== {8'h42, 1'b1}) begin errors++; $display("FAIL missing_last_ack: got id=%h err=%b required 42 1", id, e); end
        send_cmd(2'd3, 8'h77, 16'h0000, 4'd0);
        get_beat(0, r, id, e, d, l, s);
        checks++;
        if ({r, id, e, d, l} !== {1'b0, 8'h77, 1'b1, 32'h0, 1'b1}) begin
            errors++; $display("FAIL reserved_ack: got resp=%b id=%h err=%b data=%h last=%b required 0 77 1 0 1", r, id, e, d, l);
        end
        checks++;
        if ({o_scmd_accept, o_sresp_valid} !== 2'b10) begin
            errors++; $display("FAIL reserved_to_idle: got acc=%b valid=%b required 1 0", o_scmd_accept, o_sresp_valid);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic r, e, l, s; logic [7:0] id; logic [31:0] d;
        send_cmd(2'd2, 8'h66, 16'h0030, 4'd3);
        send_data(32'hC1, 1'b0, 4'hF);
        send_data(32'hC2, 1'b0, 4'hF);
        i_rst_n = 1'b0; #1;
        checks++;
        if ({o_scmd_accept, o_sdata_accept, o_sresp_valid, o_serror, o_sid, o_sdata} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got acc=%b dacc=%b valid=%b required 0 0 0",
                               o_scmd_accept, o_sdata_accept, o_sresp_valid);
        end
        @(negedge i_clk); i_rst_n = 1'b1;
        send_cmd(2'd0, 8'h67, 16'h0010, 4'd0);
        get_beat(0, r, id, e, d, l, s);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_mem_cleared: got %h required 0", d); end
        send_cmd(2'd0, 8'h68, 16'h0030, 4'd0);
        get_beat(0, r, id, e, d, l, s);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mid_reset_partial_discard: got %h required 0", d); end
    endtask

`ifdef PZCOREBUS_MEMORY_RESPONDER_BYTE_ENABLE_EN
    task automatic test_byte_enable();
        logic r, e, l, s; logic [7:0] id; logic [31:0] d;
        send_cmd(2'd2, 8'h70, 16'h0040, 4'd0);
        send_data(32'hAABBCCDD, 1'b1, 4'hF);
        get_beat(0, r, id, e, d, l, s);
        send_cmd(2'd2, 8'h71, 16'h0040, 4'd1);
        send_data(32'h11223344, 1'b0, 4'b0101);
        send_data(32'hFFFFFFFF, 1'b1, 4'b0000);
        get_beat(0, r, id, e, d, l, s);
        checks++;
        if (e !== 1'b0) begin errors++; $display("FAIL byteen_ack: err got %b required 0", e); end
        send_cmd(2'd0, 8'h72, 16'h0040, 4'd1);
        get_beat(0, r, id, e, d, l, s);
        checks++;
        if (d !== 32'hAA22CC44) begin errors++; $display("FAIL byteen_merge: got %h required aa22cc44", d); end
        get_beat(0, r, id, e, d, l, s);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL byteen_zero_noop: got %h required 0", d); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_back_pressure();
        test_out_of_range();
        test_last_marker_and_reserved();
`ifdef PZCOREBUS_MEMORY_RESPONDER_BYTE_ENABLE_EN
        test_byte_enable();
`endif
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
